// File: rtl/approx_adder_err_monitor.sv
// Error monitor for 8-bit approximate adders: scores {A,B,S,Cout} samples
// against the exact sum and reports windowed error statistics.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, busy         window start pulse (IDLE only) / not-idle flag
//   in_valid, in_ready  sample handshake
//   in_a, in_b          exact operands
//   in_s, in_cout       approximate sum bits and carry-out
//   rpt_valid/ready     report handshake
//   rpt_err_count       samples with nonzero error
//   rpt_err_sum         sum of absolute error distances
//   rpt_max_err/idx     largest error and index of its first occurrence
//   rpt_bias            signed sum of (approx - exact); zero unless the
//                       APPROX_MON_BIAS_EN macro is defined
module approx_adder_err_monitor #(
    parameter int WINDOW = 256,
    parameter int IDX_W  = $clog2(WINDOW),
    parameter int SUM_W  = 9 + IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [7:0]       in_s,
    input  logic             in_cout,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [IDX_W:0]   rpt_err_count,
    output logic [SUM_W-1:0] rpt_err_sum,
    output logic [8:0]       rpt_max_err,
    output logic [IDX_W-1:0] rpt_max_idx,
    output logic [SUM_W:0]   rpt_bias
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        REPORT
    } state_t;

    localparam logic [IDX_W:0] WIN = (IDX_W + 1)'(WINDOW);

    state_t state;
    state_t state_nx;

    logic [IDX_W:0]   sample_cnt;
    logic             drain_cnt;
    logic             xfer;
    logic             go;

    logic [8:0]       exact;
    logic [8:0]       approx;
    logic [9:0]       diff;
    logic [8:0]       err;

    logic             s1_valid;
    logic [8:0]       s1_err;
    logic [IDX_W-1:0] s1_idx;

    logic [IDX_W:0]   err_count;
    logic [SUM_W-1:0] err_sum;
    logic [8:0]       max_err;
    logic [IDX_W-1:0] max_idx;

    assign xfer = in_valid && in_ready;
    assign go   = (state == IDLE) && start;

    // Stage-1 arithmetic. diff spans -510..+511, so the magnitude always
    // fits in 9 bits and the two's-complement negate can work on the low
    // 9 bits alone.
    assign exact  = {1'b0, in_a} + {1'b0, in_b};
    assign approx = {in_cout, in_s};
    assign diff   = {1'b0, approx} - {1'b0, exact};
    assign err    = diff[9] ? (~diff[8:0] + 9'd1) : diff[8:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b1;
        in_ready  = 1'b0;
        rpt_valid = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = RUN;
            end
            RUN: begin
                in_ready = (sample_cnt < WIN);
                if (sample_cnt == WIN) state_nx = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt) state_nx = REPORT;
            end
            REPORT: begin
                rpt_valid = 1'b1;
                if (rpt_ready) state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
            drain_cnt  <= 1'b0;
            s1_valid   <= 1'b0;
            s1_err     <= '0;
            s1_idx     <= '0;
            err_count  <= '0;
            err_sum    <= '0;
            max_err    <= '0;
            max_idx    <= '0;
        end else begin
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            s1_valid  <= xfer;
            if (xfer) begin
                s1_err     <= err;
                s1_idx     <= sample_cnt[IDX_W-1:0];
                sample_cnt <= sample_cnt + (IDX_W + 1)'(1);
            end
            if (go) begin
                sample_cnt <= '0;
                err_count  <= '0;
                err_sum    <= '0;
                max_err    <= '0;
                max_idx    <= '0;
            end else if (s1_valid) begin
                err_sum   <= err_sum + SUM_W'(s1_err);
                err_count <= err_count + (IDX_W + 1)'(s1_err != 9'd0);
                // strict compare: ties keep the earliest index
                if (s1_err > max_err) begin
                    max_err <= s1_err;
                    max_idx <= s1_idx;
                end
            end
        end
    end

`ifdef APPROX_MON_BIAS_EN
    logic [9:0]   s1_diff;
    logic [SUM_W:0] bias;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_diff <= '0;
            bias    <= '0;
        end else begin
            if (xfer) s1_diff <= diff;
            if (go) begin
                bias <= '0;
            end else if (s1_valid) begin
                bias <= bias + (SUM_W + 1)'($signed(s1_diff));
            end
        end
    end

    assign rpt_bias = bias;
`else
    assign rpt_bias = '0;
`endif

    assign rpt_err_count = err_count;
    assign rpt_err_sum   = err_sum;
    assign rpt_max_err   = max_err;
    assign rpt_max_idx   = max_idx;

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Self-checking bench for approx_adder_err_monitor (WINDOW=4).
// Directed literal windows plus randomized windows against a window model.
module tb_approx_adder_err_monitor;

    localparam int WINDOW = 4;
    localparam int IDX_W  = 2;
    localparam int SUM_W  = 11;
`ifdef APPROX_MON_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
    } tup_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [7:0]       in_s;
    logic             in_cout;
    logic             rpt_valid;
    logic             rpt_ready;
    logic [IDX_W:0]   rpt_err_count;
    logic [SUM_W-1:0] rpt_err_sum;
    logic [8:0]       rpt_max_err;
    logic [IDX_W-1:0] rpt_max_idx;
    logic [SUM_W:0]   rpt_bias;

    approx_adder_err_monitor #(.WINDOW(WINDOW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_s(in_s),
        .in_cout(in_cout),
        .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready),
        .rpt_err_count(rpt_err_count),
        .rpt_err_sum(rpt_err_sum),
        .rpt_max_err(rpt_max_err),
        .rpt_max_idx(rpt_max_idx),
        .rpt_bias(rpt_bias)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- window model ----------------
    bit     run_open = 1'b0;
    tup_t   q[$];
    int     age = 0;
    longint h_cnt = 0, h_sum = 0, h_max = 0, h_idx = 0, h_bias = 0;

    function automatic void model_report();
        longint c, s, m, mi, bs;
        c = 0; s = 0; m = 0; mi = 0; bs = 0;
        for (int i = 0; i < q.size(); i++) begin
            int ex, ap, d, e;
            ex = int'(q[i].a) + int'(q[i].b);
            ap = int'(q[i].c) * 256 + int'(q[i].s);
            d  = ap - ex;
            e  = (d < 0) ? -d : d;
            s  += e;
            bs += d;
            if (e != 0) c++;
            if (e > m) begin
                m  = e;
                mi = i;
            end
        end
        h_cnt  = c;
        h_sum  = s;
        h_max  = m;
        h_idx  = mi;
        h_bias = BIAS_EN ? bs : 0;
    endfunction

    always @(negedge clk) begin
        bit full, exp_valid, c_start, c_x, c_hs;
        full = (q.size() == WINDOW);
        if (full && age < 100) age++;
        exp_valid = run_open && full && (age >= 4);
        if (!rst) begin
            chk("busy", busy, run_open);
            chk("in_ready", in_ready, run_open && !full);
            chk("rpt_valid", rpt_valid, exp_valid);
            if (exp_valid || !run_open) begin
                chk("err_count", rpt_err_count, h_cnt);
                chk("err_sum", rpt_err_sum, h_sum);
                chk("max_err", rpt_max_err, h_max);
                chk("max_idx", rpt_max_idx, h_idx);
                chk("bias", $signed(rpt_bias), h_bias);
            end
        end
        c_start = !run_open && start;
        c_x     = run_open && !full && in_valid;
        c_hs    = exp_valid && rpt_ready;
        if (rst) begin
            run_open = 1'b0;
            q.delete();
            age = 0;
            h_cnt = 0; h_sum = 0; h_max = 0; h_idx = 0; h_bias = 0;
        end else begin
            if (c_start) begin
                run_open = 1'b1;
                q.delete();
                age = 0;
            end
            if (c_x) begin
                q.push_back('{a: in_a, b: in_b, s: in_s, c: in_cout});
                if (q.size() == WINDOW) begin
                    age = 0;
                    model_report();
                end
            end
            if (c_hs) run_open = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    tup_t w[WINDOW];

    function automatic tup_t tp(logic [7:0] a, logic [7:0] b,
                                logic [7:0] s, logic c);
        tup_t t;
        t.a = a; t.b = b; t.s = s; t.c = c;
        return t;
    endfunction

    function automatic tup_t rnd(bit err_on);
        tup_t t;
        logic [8:0] x;
        t.a = 8'($urandom);
        t.b = 8'($urandom);
        x = {1'b0, t.a} + {1'b0, t.b};
        t.s = x[7:0];
        t.c = x[8];
        if (err_on) begin
            t.s = 8'($urandom);
            t.c = 1'($urandom);
        end
        return t;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input tup_t t);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        in_a = t.a; in_b = t.b; in_s = t.s; in_cout = t.c;
        in_valid = 1'b1;
        while (!ok && n < 20) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) chk("xfer_timeout", 0, 1);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_report(input int hold, input bit lit,
                               input longint ec, input longint es,
                               input longint em, input longint ei,
                               input longint eb);
        int n;
        n = 0;
        @(negedge clk);
        while (!rpt_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rpt_valid) begin
            chk("rpt_timeout", 0, 1);
        end else if (lit) begin
            chk("lit_count", rpt_err_count, ec);
            chk("lit_sum", rpt_err_sum, es);
            chk("lit_max", rpt_max_err, em);
            chk("lit_idx", rpt_max_idx, ei);
            chk("lit_bias", $signed(rpt_bias), eb);
        end
        repeat (hold) begin
            @(negedge clk);
            chk("busy_hold", busy, 1);
        end
        @(posedge clk); #1;
        rpt_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rpt_ready = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_hs", busy, 0);
    endtask

    task automatic run_win(input bit poke, input int hold, input bit lit,
                           input longint ec, input longint es,
                           input longint em, input longint ei,
                           input longint eb);
        pulse_start();
        for (int i = 0; i < WINDOW; i++) begin
            send(w[i]);
            if (poke && i == 1) pulse_start();
        end
        wait_report(hold, lit, ec, es, em, ei, eb);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_a = '0; in_b = '0; in_s = '0; in_cout = 1'b0;
        rpt_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rpt_valid", rpt_valid, 0);
        chk("rst_sum", rpt_err_sum, 0);

        // samples offered while idle must not transfer
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_a = 8'h11; in_s = 8'h00;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;

        // all-exact window
        w[0] = tp(8'h12, 8'h34, 8'h46, 1'b0);
        for (int i = 1; i < WINDOW; i++) w[i] = rnd(1'b0);
        run_win(1'b0, 0, 1'b1, 0, 0, 0, 0, 0);

        // one MSB-sized error at index 2
        for (int i = 0; i < WINDOW; i++) w[i] = rnd(1'b0);
        w[2] = tp(8'h80, 8'h80, 8'h80, 1'b0);
        run_win(1'b0, 0, 1'b1, 1, 128, 128, 2, BIAS_EN ? -128 : 0);

        // ties: errors 5, 9, 9, 3; start poked mid-run, report held
        w[0] = tp(8'd10, 8'd10, 8'd25, 1'b0);
        w[1] = tp(8'd10, 8'd10, 8'd29, 1'b0);
        w[2] = tp(8'd10, 8'd10, 8'd11, 1'b0);
        w[3] = tp(8'd10, 8'd10, 8'd17, 1'b0);
        run_win(1'b1, 10, 1'b1, 4, 26, 9, 1, BIAS_EN ? 2 : 0);

        // maximum error
        for (int i = 0; i < WINDOW; i++) w[i] = rnd(1'b0);
        w[0] = tp(8'h00, 8'h00, 8'hFF, 1'b1);
        run_win(1'b0, 1, 1'b1, 1, 511, 511, 0, BIAS_EN ? 511 : 0);

        // reset after two erroneous samples
        pulse_start();
        send(tp(8'h01, 8'h01, 8'h55, 1'b1));
        send(tp(8'h02, 8'h02, 8'h99, 1'b0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_count", rpt_err_count, 0);
        chk("mid_rst_sum", rpt_err_sum, 0);
        chk("mid_rst_max", rpt_max_err, 0);
        chk("mid_rst_idx", rpt_max_idx, 0);
        chk("mid_rst_bias", $signed(rpt_bias), 0);
        for (int i = 0; i < WINDOW; i++) w[i] = rnd(1'($urandom));
        run_win(1'b0, 0, 1'b0, 0, 0, 0, 0, 0);

        // randomized windows
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < WINDOW; i++) w[i] = rnd(1'($urandom));
            run_win(1'($urandom), $urandom_range(0, 3), 1'b0, 0, 0, 0, 0, 0);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
